// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: owns the PC, issues imem word fetches, applies EX redirects.
// Optional MISALIGN_TRAP_EN: misaligned redirect targets enter a sticky TRAP state.
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_base_i,
  input  logic [31:0] redirect_imm_i,
  input  logic        redirect_is_jalr_i,
  input  logic        imem_ready_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_pc_o,
  output logic        flush_o,
  output logic        trap_o
);

  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    S_BOOT, S_RUN, S_WAIT, S_FLUSH, S_TRAP
  } state_e;
`else
  typedef enum logic [2:0] {
    S_BOOT, S_RUN, S_WAIT, S_FLUSH
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        valid_q, valid_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] sum;
  logic [31:0] target;
  logic        req;
  logic        hs;
  logic        redir;
`ifdef MISALIGN_TRAP_EN
  logic        trap_q, trap_d;
  logic        misalign;
`endif

  always_comb begin
    sum = redirect_base_i + redirect_imm_i;
    if (redirect_is_jalr_i) begin
      sum[0] = 1'b0;
    end
`ifdef MISALIGN_TRAP_EN
    target   = sum;
    misalign = |sum[1:0];
`else
    target   = {sum[31:2], 2'b00};
`endif
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    valid_d = 1'b0;
    fpc_d   = 32'h0;
    req     = 1'b0;
    redir   = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap_d  = trap_q;
`endif
    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        req   = !stall_i;
        redir = redirect_valid_i;
      end
      S_WAIT: begin
        req   = 1'b1;
        redir = redirect_valid_i;
      end
      S_FLUSH: begin
        redir = redirect_valid_i;
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          state_d = S_RUN;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          flush_d = 1'b1;
        end
      end
`ifdef MISALIGN_TRAP_EN
      S_TRAP: begin
        flush_d = 1'b1;
      end
`endif
      default: begin
        state_d = S_BOOT;
      end
    endcase

    hs = req & imem_ready_i;

    // A redirect kills any in-flight handshake, including a WAIT acceptance
    if (redir) begin
      pc_d    = target;
      state_d = S_FLUSH;
      cnt_d   = FC;
      flush_d = 1'b1;
`ifdef MISALIGN_TRAP_EN
      if (misalign) begin
        state_d = S_TRAP;
        trap_d  = 1'b1;
      end
`endif
    end else if (hs) begin
      pc_d    = pc_q + 32'd4;
      state_d = S_RUN;
      valid_d = 1'b1;
      fpc_d   = pc_q;
    end else if (req) begin
      state_d = S_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= 3'd0;
      flush_q <= 1'b0;
      valid_q <= 1'b0;
      fpc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      valid_q <= valid_d;
      fpc_q   <= fpc_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end
  assign trap_o = trap_q;
`else
  assign trap_o = 1'b0;
`endif

  assign imem_req_o    = req;
  assign imem_addr_o   = pc_q;
  assign fetch_valid_o = valid_q;
  assign fetch_pc_o    = fpc_q;
  assign flush_o       = flush_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Scoreboard bench for fetch_pc_sequencer: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_pc_sequencer;

  localparam int          FC  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        rv = 1'b0;
  logic [31:0] base = 32'h0;
  logic [31:0] imm = 32'h0;
  logic        jalr = 1'b0;
  logic        ready = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        fetch_valid_o;
  logic [31:0] fetch_pc_o;
  logic        flush_o;
  logic        trap_o;

  fetch_pc_sequencer #(
    .RESET_PC    (RPC),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall),
    .redirect_valid_i  (rv),
    .redirect_base_i   (base),
    .redirect_imm_i    (imm),
    .redirect_is_jalr_i(jalr),
    .imem_ready_i      (ready),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .fetch_valid_o     (fetch_valid_o),
    .fetch_pc_o        (fetch_pc_o),
    .flush_o           (flush_o),
    .trap_o            (trap_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];

  bit          m_boot;
  bit          m_pend;
  bit          m_trap;
  int          m_flush;
  logic [31:0] m_pc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_pend  = 1'b0;
    m_trap  = 1'b0;
    m_flush = 0;
    m_pc    = RPC;
  endtask

  // Called at a falling edge: drive one cycle, check, advance the model.
  task automatic step(input bit s, input bit r, input bit rd,
                      input logic [31:0] b, input logic [31:0] i,
                      input bit j);
    bit          er;
    logic [31:0] t;
    stall = s;
    ready = r;
    rv    = rd;
    base  = b;
    imm   = i;
    jalr  = j;
    #1;
    er = !m_boot && !m_trap && m_flush == 0 && (m_pend || !s);
    chk1("req", imem_req_o, er);
    chk("addr", imem_addr_o, m_pc);
    chk1("flush", flush_o, m_trap || m_flush > 0);
    chk1("trap", trap_o, m_trap);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_trap) begin
      m_trap = 1'b1;
    end else if (rd) begin
      t = b + i;
      if (j) t[0] = 1'b0;
`ifdef MISALIGN_TRAP_EN
      if (t[1:0] != 2'b00) m_trap = 1'b1;
`else
      t[1:0] = 2'b00;
`endif
      m_pc    = t;
      m_pend  = 1'b0;
      m_flush = FC;
    end else if (m_flush > 0) begin
      m_flush--;
    end else if (er) begin
      if (r) begin
        exp_q.push_back(m_pc);
        m_pc   = m_pc + 32'd4;
        m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit s, input bit r);
    step(s, r, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_req", imem_req_o, 1'b0);
    chk("rst_addr", imem_addr_o, RPC);
    chk1("rst_valid", fetch_valid_o, 1'b0);
    chk("rst_fpc", fetch_pc_o, 32'h0);
    chk1("rst_flush", flush_o, 1'b0);
    chk1("rst_trap", trap_o, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  always @(posedge clk) begin
    #1;
    if (fetch_valid_o) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_fetch: got pc %h expected none", fetch_pc_o);
      end else begin
        chk("fetch_pc", fetch_pc_o, exp_q.pop_front());
      end
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL missing_fetch: got none expected pc %h", exp_q[0]);
      exp_q.delete();
    end
  end

  initial begin
    logic [31:0] rb;
    logic [31:0] ri;
    repeat (3) @(negedge clk);
    chk1("init_req", imem_req_o, 1'b0);
    chk1("init_valid", fetch_valid_o, 1'b0);
    chk1("init_flush", flush_o, 1'b0);
    chk("init_addr", imem_addr_o, RPC);
    rst_n = 1'b1;
    model_reset();

    idle(0, 1);
    idle(0, 1);
    idle(0, 1);
    idle(0, 0);
    idle(1, 0);
    idle(0, 0);
    idle(0, 1);

    step(0, 1, 1, 32'h100, 32'hFFFF_FFF0, 0);
    repeat (3) idle(0, 1);

    step(0, 1, 1, 32'hFFFF_FFFC, 32'h8, 0);
    repeat (4) idle(0, 1);

    step(0, 1, 1, 32'h203, 32'h4, 1);
    repeat (4) idle(0, 1);

    step(0, 1, 1, 32'h500, 32'h0, 0);
    step(1, 1, 1, 32'h400, 32'h0, 0);
    repeat (3) idle(1, 1);
    repeat (2) idle(0, 1);

    do_reset();
    repeat (3) idle(0, 1);
    idle(0, 0);
    idle(1, 0);
    do_reset();
    repeat (3) idle(0, 1);

    step(0, 0, 0, 32'h0, 32'h0, 0);
    step(0, 1, 1, 32'h40, 32'h0, 0);
    repeat (4) idle(0, 1);

    for (int k = 0; k < 1500; k++) begin
      rb = $urandom;
      ri = $urandom;
`ifdef MISALIGN_TRAP_EN
      rb[1:0] = 2'b00;
      ri[1:0] = 2'b00;
`endif
      step(($urandom % 4) == 0, ($urandom % 3) != 0,
           ($urandom % 12) == 0, rb, ri, $urandom % 2 == 1);
    end
    repeat (3) idle(0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
